// File: rtl/regfile_2r2w_if.sv
// Bus bundle for the dual-issue register file: two write ports, two read ports,
// scoreboard issue, and bulk-clear control.
interface regfile_2r2w_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4
);
   logic              we0, we1;
   logic [ADDR_W-1:0] wa0, wa1;
   logic [DATA_W-1:0] wd0, wd1;
   logic [ADDR_W-1:0] ra0, ra1;
   logic [DATA_W-1:0] rd0, rd1;
   logic              rp0, rp1;
   logic              iss_valid;
   logic [ADDR_W-1:0] iss_rd;
   logic              clr_start;
   logic              clr_busy;
   logic              clr_done;

   modport master (
      output we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, iss_valid, iss_rd, clr_start,
      input  rd0, rd1, rp0, rp1, clr_busy, clr_done
   );

   modport slave (
      input  we0, we1, wa0, wa1, wd0, wd1, ra0, ra1, iss_valid, iss_rd, clr_start,
      output rd0, rd1, rp0, rp1, clr_busy, clr_done
   );
endinterface

// File: rtl/regfile_2r2w.sv
// 2-read/2-write register file with write forwarding, a pending-producer
// scoreboard and a one-entry-per-cycle bulk-clear sequencer.
module regfile_2r2w #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter bit ZERO_REG = 1'b1
) (
   input logic             clk,
   input logic             rst_n,
   regfile_2r2w_if.slave   bus
);
   localparam int                DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t                          r_state, w_state_nxt;
   logic [ADDR_W-1:0]               r_cptr;
   logic [DEPTH-1:0][DATA_W-1:0]    r_regs;
   logic [DEPTH-1:0]                r_pend;
   logic                            r_done;

   logic                            w_idle;
   logic                            w_wq0, w_wq1;
   logic [1:0][ADDR_W-1:0]          w_ra;
   logic [1:0][DATA_W-1:0]          w_rd;
   logic [1:0]                      w_rp;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.clr_start)  w_state_nxt = S_CLEAR;
         S_CLEAR: if (r_cptr == LAST) w_state_nxt = S_IDLE;
         default:                     w_state_nxt = S_IDLE;
      endcase
   end

   // outputs: write qualification, forwarding read muxes, pending flags
   always_comb begin
      w_idle = (r_state == S_IDLE);
      w_wq0  = bus.we0 && w_idle && !(ZERO_REG && bus.wa0 == '0);
      w_wq1  = bus.we1 && w_idle && !(ZERO_REG && bus.wa1 == '0);
      w_ra[0] = bus.ra0;
      w_ra[1] = bus.ra1;
      for (int p = 0; p < 2; p++) begin
         if (ZERO_REG && w_ra[p] == '0)     w_rd[p] = '0;
         else if (w_wq1 && bus.wa1 == w_ra[p]) w_rd[p] = bus.wd1;
         else if (w_wq0 && bus.wa0 == w_ra[p]) w_rd[p] = bus.wd0;
         else                                  w_rd[p] = r_regs[w_ra[p]];
         w_rp[p] = r_pend[w_ra[p]] && !(w_wq0 && bus.wa0 == w_ra[p])
                   && !(w_wq1 && bus.wa1 == w_ra[p])
                   && !(ZERO_REG && w_ra[p] == '0);
      end
      bus.rd0      = w_rd[0];
      bus.rd1      = w_rd[1];
      bus.rp0      = w_rp[0];
      bus.rp1      = w_rp[1];
      bus.clr_busy = (r_state == S_CLEAR);
      bus.clr_done = r_done;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cptr <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= (r_state == S_CLEAR) && (r_cptr == LAST);
         if (r_state == S_CLEAR) r_cptr <= r_cptr + 1'b1;
         else                    r_cptr <= '0;
      end
   end

   // port 1 is written last so it wins a same-address collision
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_regs <= '0;
      end else if (r_state == S_CLEAR) begin
         r_regs[r_cptr] <= '0;
      end else begin
         if (w_wq0) r_regs[bus.wa0] <= bus.wd0;
         if (w_wq1) r_regs[bus.wa1] <= bus.wd1;
      end
   end

   // a new producer supersedes a retiring one, so set beats clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
      end else if (w_idle && bus.clr_start) begin
         r_pend <= '0;
      end else if (w_idle) begin
         for (int r = 0; r < DEPTH; r++) begin
            if (bus.iss_valid && bus.iss_rd == ADDR_W'(r) && !(ZERO_REG && r == 0))
               r_pend[r] <= 1'b1;
            else if ((w_wq0 && bus.wa0 == ADDR_W'(r)) || (w_wq1 && bus.wa1 == ADDR_W'(r)))
               r_pend[r] <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_regfile_2r2w.sv
// Directed bench for regfile_2r2w: forwarding, zero register, scoreboard,
// bulk clear timing and reset abort of a clear.
module tb_regfile_2r2w;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_pass = 0;

   regfile_2r2w_if #(.DATA_W(16), .ADDR_W(4)) bus ();

   regfile_2r2w #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1'b1)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      bus.we0 = 0; bus.we1 = 0; bus.wa0 = 0; bus.wa1 = 0; bus.wd0 = 0; bus.wd1 = 0;
      bus.ra0 = 0; bus.ra1 = 0; bus.iss_valid = 0; bus.iss_rd = 0; bus.clr_start = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_in();
      bus.ra0 = 4'd3;
      #22;
      chk("rst_busy", bus.clr_busy, 0);
      chk("rst_done", bus.clr_done, 0);
      chk("rst_rd0",  bus.rd0, 0);
      chk("rst_rp0",  bus.rp0, 0);
      rst_n = 1'b1;
      tick();

      // two-port write then read back from the array
      bus.we0 = 1; bus.wa0 = 4'd3; bus.wd0 = 16'h1234;
      bus.we1 = 1; bus.wa1 = 4'd5; bus.wd1 = 16'hBEEF;
      tick();
      idle_in();
      bus.ra0 = 4'd3; bus.ra1 = 4'd5;
      #1;
      chk("wr_rd0", bus.rd0, 16'h1234);
      chk("wr_rd1", bus.rd1, 16'hBEEF);

      // same-address collision: port 1 wins, forwarded and stored
      bus.we0 = 1; bus.wa0 = 4'd7; bus.wd0 = 16'h1111;
      bus.we1 = 1; bus.wa1 = 4'd7; bus.wd1 = 16'h2222;
      bus.ra0 = 4'd7;
      #1;
      chk("coll_fwd", bus.rd0, 16'h2222);
      tick();
      idle_in();
      bus.ra0 = 4'd7;
      #1;
      chk("coll_arr", bus.rd0, 16'h2222);

      // port-0 forwarding on the other read port
      bus.we0 = 1; bus.wa0 = 4'd8; bus.wd0 = 16'hAAAA; bus.ra1 = 4'd8;
      #1;
      chk("fwd0_rd1", bus.rd1, 16'hAAAA);
      tick();
      idle_in();

      // zero register
      bus.we0 = 1; bus.wa0 = 4'd0; bus.wd0 = 16'hFFFF; bus.ra0 = 4'd0;
      #1;
      chk("zr_fwd", bus.rd0, 0);
      tick();
      idle_in();
      #1;
      chk("zr_rd", bus.rd0, 0);
      bus.iss_valid = 1; bus.iss_rd = 4'd0;
      tick();
      idle_in();
      #1;
      chk("zr_rp", bus.rp0, 0);

      // scoreboard
      bus.iss_valid = 1; bus.iss_rd = 4'd9;
      tick();
      idle_in();
      bus.ra0 = 4'd9;
      #1;
      chk("sb_set", bus.rp0, 1);
      bus.we1 = 1; bus.wa1 = 4'd9; bus.wd1 = 16'h0099;
      bus.iss_valid = 1; bus.iss_rd = 4'd9;
      #1;
      chk("sb_unblk", bus.rp0, 0);
      tick();
      idle_in();
      bus.ra0 = 4'd9;
      #1;
      chk("sb_setwin", bus.rp0, 1);
      chk("sb_rd", bus.rd0, 16'h0099);
      bus.we0 = 1; bus.wa0 = 4'd9; bus.wd0 = 16'h0055;
      #1;
      chk("sb_retire_now", bus.rp0, 0);
      chk("sb_retire_fwd", bus.rd0, 16'h0055);
      tick();
      idle_in();
      bus.ra0 = 4'd9;
      #1;
      chk("sb_retire_after", bus.rp0, 0);

      // preload r1..r15 = index, leave r2 pending
      for (int i = 1; i < 16; i++) begin
         bus.we0 = 1; bus.wa0 = 4'(i); bus.wd0 = 16'(i);
         tick();
      end
      idle_in();
      bus.iss_valid = 1; bus.iss_rd = 4'd2;
      tick();
      idle_in();
      bus.ra1 = 4'd2;
      #1;
      chk("pre_rp1", bus.rp1, 1);

      // bulk clear: cycle T
      bus.clr_start = 1;
      #1;
      chk("clr_T_busy", bus.clr_busy, 0);
      tick();
      bus.clr_start = 0;
      for (int k = 1; k <= 16; k++) begin
         bus.ra1 = 4'(k - 1);
         bus.ra0 = (k >= 2) ? 4'(k - 2) : 4'd15;
         bus.we0 = (k == 5); bus.wa0 = 4'd4; bus.wd0 = 16'hDEAD;
         bus.clr_start = (k == 10);
         #1;
         chk($sformatf("clr_busy_%0d", k), bus.clr_busy, 1);
         chk($sformatf("clr_done_%0d", k), bus.clr_done, 0);
         chk($sformatf("clr_old_%0d", k), bus.rd1, 32'(k - 1));
         chk($sformatf("clr_new_%0d", k), bus.rd0, (k >= 2) ? 0 : 15);
         tick();
      end
      idle_in();
      #1;
      chk("clr_end_busy", bus.clr_busy, 0);
      chk("clr_end_done", bus.clr_done, 1);
      bus.we0 = 1; bus.wa0 = 4'd6; bus.wd0 = 16'h0066;
      tick();
      idle_in();
      #1;
      chk("clr_done_off", bus.clr_done, 0);
      chk("clr_busy_off", bus.clr_busy, 0);
      for (int i = 0; i < 16; i++) begin
         bus.ra0 = 4'(i); bus.ra1 = 4'(i);
         #1;
         chk($sformatf("post_rd_%0d", i), bus.rd0, (i == 6) ? 16'h0066 : 0);
         chk($sformatf("post_rp_%0d", i), bus.rp1, 0);
      end

      // reset in the middle of a clear
      idle_in();
      bus.we0 = 1; bus.wa0 = 4'd12; bus.wd0 = 16'hC0DE;
      tick();
      idle_in();
      bus.clr_start = 1;
      tick();
      bus.clr_start = 0;
      for (int k = 0; k < 7; k++) tick();
      bus.ra0 = 4'd12;
      #1;
      chk("mid_busy", bus.clr_busy, 1);
      chk("mid_old", bus.rd0, 16'hC0DE);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", bus.clr_busy, 0);
      chk("abort_rd", bus.rd0, 0);
      #2;
      rst_n = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         chk($sformatf("abort_nodone_%0d", k), bus.clr_done, 0);
      end
      chk("abort_idle_busy", bus.clr_busy, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
